// File: rtl/sensor_acq_responder.sv
// Sensor-slot responder: on an accepted trigger it pulses start, gathers NUM_CH
// words from the front-end, then publishes them all at once and holds done high.
module sensor_acq_responder #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 16,
    parameter int TMO_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trigger,
    input  logic                     en,
    input  logic [TMO_W-1:0]         timeout_cycles,
    input  logic                     clr_err,
    output logic                     start,
    input  logic                     ch_valid,
    input  logic [DATA_W-1:0]        ch_data,
    output logic                     done,
    output logic                     busy,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic [31:0]              sample_count,
    output logic                     timeout_err,
    output logic                     overrun_err
);
    localparam int CNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               word_cnt;
    logic [TMO_W-1:0]               tmo_cnt;
    logic [NUM_CH-1:0][DATA_W-1:0]  shadow, shadow_fin, data_q;
    logic                           collecting, accept, complete, tmo_hit;

    assign collecting = (state_q == COLLECT) && en;
    assign accept     = trigger && en && (state_q != COLLECT);
    assign complete   = collecting && ch_valid && (word_cnt == CNT_W'(NUM_CH - 1));
    // A completing valid on the timeout cycle wins over the timeout.
    assign tmo_hit    = collecting && (timeout_cycles != '0) && !complete &&
                        (tmo_cnt == timeout_cycles - TMO_W'(1));

    // Final word bypasses the shadow so every word publishes on the same edge.
    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_fin
            assign shadow_fin[k] = (word_cnt == CNT_W'(k)) ? ch_data : shadow[k];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept)   state_d = COLLECT;
                else if (!en) state_d = IDLE;
            end
            COLLECT: begin
                if (!en)                      state_d = IDLE;
                else if (complete || tmo_hit) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start        <= 1'b0;
            word_cnt     <= '0;
            tmo_cnt      <= '0;
            shadow       <= '0;
            data_q       <= '0;
            sample_count <= '0;
            timeout_err  <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            start <= accept;
            if (accept) begin
                word_cnt <= '0;
                tmo_cnt  <= '0;
            end else if (collecting) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
                if (ch_valid) begin
                    word_cnt <= word_cnt + CNT_W'(1);
                    for (int i = 0; i < NUM_CH; i++)
                        if (word_cnt == CNT_W'(i)) shadow[i] <= ch_data;
                end
            end
            if (complete) begin
                data_q       <= shadow_fin;
                sample_count <= sample_count + 32'd1;
            end
            if (tmo_hit)      timeout_err <= 1'b1;
            else if (clr_err) timeout_err <= 1'b0;
            if (collecting && trigger) overrun_err <= 1'b1;
            else if (clr_err)          overrun_err <= 1'b0;
        end
    end

    assign done     = (state_q == DONE);
    assign busy     = (state_q == COLLECT);
    assign data_out = data_q;
endmodule
